// File: rtl/i2c_target_phy.sv
// I2C target (slave) PHY: oversampled SCL/SDA, START/STOP detection, 7-bit address match,
// write-byte reception and read-byte transmission with open-drain SDA and no clock stretching.
module i2c_target_phy #(
  parameter logic [6:0]  SLAVE_ADDR  = 7'h50,
  parameter int unsigned FILTER_LEN  = 3,
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i2c_scl,
  inout  wire        i2c_sda,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_nack,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic       start_det,
  output logic       stop_det,
  output logic       addressed,
  output logic       rw
);

  localparam logic [3:0] FLT_MAX  = 4'(FILTER_LEN);
  localparam logic [3:0] HOLD_MAX = 4'(HOLD_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_WR_BYTE,
    S_WR_ACK,
    S_RD_BYTE,
    S_RD_ACK,
    S_IGNORE
  } state_t;

  logic [1:0] r_scl_s;
  logic [1:0] r_sda_s;
  logic       r_scl_f;
  logic       r_sda_f;
  logic [3:0] r_scl_cnt;
  logic [3:0] r_sda_cnt;
  logic       r_scl_d;
  logic       r_sda_d;

  state_t     r_state;
  logic [3:0] r_bit_cnt;
  logic [6:0] r_shift;
  logic [6:0] r_tx_shift;
  logic       r_ack_pend;
  logic       r_sda_oe;
  logic       r_oe_next;
  logic       r_hold_act;
  logic [3:0] r_hold_cnt;

  logic [7:0] r_rx_data;
  logic       r_rx_valid;
  logic       r_tx_req;
  logic       r_start_det;
  logic       r_stop_det;
  logic       r_addressed;
  logic       r_rw;

  logic       w_scl_rise;
  logic       w_scl_fall;
  logic       w_start;
  logic       w_stop;
  logic [7:0] w_shift_in;
  logic       w_oe_next;

  assign i2c_sda = r_sda_oe ? 1'b0 : 1'bz;

  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
  assign tx_req    = r_tx_req;
  assign start_det = r_start_det;
  assign stop_det  = r_stop_det;
  assign addressed = r_addressed;
  assign rw        = r_rw;

  // Synchronizers and glitch filters; everything downstream sees only the filtered lines.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_scl_s   <= 2'b11;
      r_sda_s   <= 2'b11;
      r_scl_f   <= 1'b1;
      r_sda_f   <= 1'b1;
      r_scl_cnt <= '0;
      r_sda_cnt <= '0;
      r_scl_d   <= 1'b1;
      r_sda_d   <= 1'b1;
    end else begin
      r_scl_s <= {r_scl_s[0], i2c_scl};
      r_sda_s <= {r_sda_s[0], i2c_sda};
      r_scl_d <= r_scl_f;
      r_sda_d <= r_sda_f;

      if (r_scl_s[1] == r_scl_f) begin
        r_scl_cnt <= '0;
      end else if (r_scl_cnt + 4'd1 >= FLT_MAX) begin
        r_scl_f   <= r_scl_s[1];
        r_scl_cnt <= '0;
      end else begin
        r_scl_cnt <= r_scl_cnt + 4'd1;
      end

      if (r_sda_s[1] == r_sda_f) begin
        r_sda_cnt <= '0;
      end else if (r_sda_cnt + 4'd1 >= FLT_MAX) begin
        r_sda_f   <= r_sda_s[1];
        r_sda_cnt <= '0;
      end else begin
        r_sda_cnt <= r_sda_cnt + 4'd1;
      end
    end
  end

  assign w_scl_rise = r_scl_f & ~r_scl_d;
  assign w_scl_fall = ~r_scl_f & r_scl_d;
  assign w_start    = r_scl_f & r_scl_d & r_sda_d & ~r_sda_f;
  assign w_stop     = r_scl_f & r_scl_d & ~r_sda_d & r_sda_f;
  assign w_shift_in = {r_shift, r_sda_f};

  // SDA drive level for the bit slot that the current SCL falling edge opens.
  always_comb begin
    w_oe_next = 1'b0;
    case (r_state)
      S_ADDR_ACK: w_oe_next = 1'b1;
      S_WR_ACK:   w_oe_next = r_ack_pend;
      S_RD_BYTE:  w_oe_next = (r_bit_cnt == 4'd0) ? ~tx_data[7] : ~r_tx_shift[6];
      default:    w_oe_next = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_tx_shift  <= '0;
      r_ack_pend  <= 1'b0;
      r_sda_oe    <= 1'b0;
      r_oe_next   <= 1'b0;
      r_hold_act  <= 1'b0;
      r_hold_cnt  <= '0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_tx_req    <= 1'b0;
      r_start_det <= 1'b0;
      r_stop_det  <= 1'b0;
      r_addressed <= 1'b0;
      r_rw        <= 1'b0;
    end else begin
      r_rx_valid  <= 1'b0;
      r_tx_req    <= 1'b0;
      r_start_det <= 1'b0;
      r_stop_det  <= 1'b0;

      if (r_hold_act) begin
        if (r_hold_cnt >= HOLD_MAX) begin
          r_sda_oe   <= r_oe_next;
          r_hold_act <= 1'b0;
        end else begin
          r_hold_cnt <= r_hold_cnt + 4'd1;
        end
      end

      if (w_start) begin
        r_start_det <= 1'b1;
        r_sda_oe    <= 1'b0;
        r_hold_act  <= 1'b0;
        r_bit_cnt   <= '0;
        r_addressed <= 1'b0;
        r_state     <= S_ADDR;
      end else if (w_stop) begin
        r_stop_det  <= 1'b1;
        r_sda_oe    <= 1'b0;
        r_hold_act  <= 1'b0;
        r_addressed <= 1'b0;
        r_state     <= S_IDLE;
      end else if (w_scl_rise) begin
        r_shift   <= w_shift_in[6:0];
        r_bit_cnt <= (r_bit_cnt == 4'd8) ? 4'd0 : r_bit_cnt + 4'd1;
        case (r_state)
          S_ADDR: begin
            if (r_bit_cnt == 4'd7) begin
              if (w_shift_in[7:1] == SLAVE_ADDR) begin
                r_rw        <= w_shift_in[0];
                r_addressed <= 1'b1;
                r_state     <= S_ADDR_ACK;
              end else begin
                r_state <= S_IGNORE;
              end
            end
          end
          S_ADDR_ACK: begin
            if (r_rw) begin
              r_tx_req <= 1'b1;
              r_state  <= S_RD_BYTE;
            end else begin
              r_state <= S_WR_BYTE;
            end
          end
          S_WR_BYTE: begin
            if (r_bit_cnt == 4'd7) begin
              r_rx_data  <= w_shift_in;
              r_rx_valid <= 1'b1;
              r_ack_pend <= ~rx_nack;
              r_state    <= S_WR_ACK;
            end
          end
          S_WR_ACK: r_state <= S_WR_BYTE;
          S_RD_BYTE: begin
            if (r_bit_cnt == 4'd7) r_state <= S_RD_ACK;
          end
          S_RD_ACK: begin
            if (!r_sda_f) begin
              r_tx_req <= 1'b1;
              r_state  <= S_RD_BYTE;
            end else begin
              r_state <= S_IGNORE;
            end
          end
          default: ;
        endcase
      end else if (w_scl_fall) begin
        if (r_state == S_RD_BYTE) begin
          r_tx_shift <= (r_bit_cnt == 4'd0) ? tx_data[6:0] : {r_tx_shift[5:0], 1'b0};
        end
        // Detection lags the filtered edge by one cycle, so the hold count starts at 2.
        if (HOLD_MAX <= 4'd1) begin
          r_sda_oe   <= w_oe_next;
          r_hold_act <= 1'b0;
        end else begin
          r_oe_next  <= w_oe_next;
          r_hold_act <= 1'b1;
          r_hold_cnt <= 4'd2;
        end
      end
    end
  end

endmodule

// File: doc/i2c_target_phy.md
# i2c_target_phy

I2C target-side (slave) physical/link layer. It is the counterpart of the I2C master PHY on the same bus. It oversamples SCL/SDA in the system clock domain, detects START/STOP, and matches a fixed 7-bit address. It ACKs, shifts write bytes out to the host logic and shifts read bytes onto SDA. It does no clock stretching, so the host must meet the tx_data deadline below.

## Interface
- SLAVE_ADDR, 7'h50, 7-bit address this target responds to.
- FILTER_LEN, 3, consecutive identical samples (clk cycles) needed before a filtered line value changes; legal range 1..15.
- HOLD_CYCLES, 4, clk cycles after a filtered SCL falling edge before SDA drive is allowed to change; legal range 1..15.
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- i2c_scl  input  1  bus clock; never driven by this block.
- i2c_sda  inout  1  bus data; open-drain, driven 0 or released (z), never driven 1.
- rx_data  output  8  last byte written by the master; stable until the next rx_valid.
- rx_valid  output  1  one-cycle pulse when rx_data is updated.
- rx_nack  input  1  sampled at each write-data ACK slot; 1 = NACK that byte.
- tx_data  input  8  byte to send to the master.
- tx_req  output  1  one-cycle pulse requesting the next tx_data.
- start_det  output  1  one-cycle pulse on START or repeated START.
- stop_det  output  1  one-cycle pulse on STOP.
- addressed  output  1  high from the address ACK until STOP or the next START.
- rw  output  1  R/W bit of the current transaction (1 = master reads); valid while addressed.

## Operation
- Input path: 2-FF synchronizer per line, then a per-line filter that updates its value only after FILTER_LEN equal consecutive samples. All edge and condition detection uses the filtered values (scl_f, sda_f).
- START = sda_f falls while scl_f is high. STOP = sda_f rises while scl_f is high. Either is recognised in every state, including mid-byte.
  - START: release SDA, clear bit counter, go to ADDR.
  - STOP: release SDA, go to IDLE.
- Data is sampled on scl_f rising edges. SDA drive changes HOLD_CYCLES after scl_f falling edges.
- States:
  - IDLE: SDA released; wait for START.
  - ADDR: shift 8 bits MSB first.
    - On the 8th rising edge, compare bits[7:1] with SLAVE_ADDR.
    - Match: latch rw = bit0 and go to ADDR_ACK.
    - Mismatch: go to IGNORE.
  - ADDR_ACK: drive SDA 0 for the 9th bit and assert addressed.
    - At the 9th rising edge: if rw=1, pulse tx_req and go to RD_BYTE; else go to WR_BYTE.
  - WR_BYTE: shift 8 bits. On the 8th rising edge, update rx_data, pulse rx_valid and latch ~rx_nack into ack_pending; go to WR_ACK.
  - WR_ACK: drive SDA 0 if ack_pending, else release. At the 9th rising edge, go to WR_BYTE. A NACKed byte does not end the transaction.
  - RD_BYTE: on the falling edge that ends the preceding ACK slot, load the shift register from tx_data. Drive bit7 first, then one bit per falling edge, MSB first; 0 = drive low, 1 = release.
    - After the 8th bit's falling edge, release SDA and go to RD_ACK.
  - RD_ACK: sample SDA at the 9th rising edge.
    - 0 (master ACK): pulse tx_req and go to RD_BYTE.
    - 1 (NACK): go to IGNORE.
  - IGNORE: SDA released; wait for START or STOP.
- Bit counter is 4 bits and counts 0..8 per byte including the ACK slot. It wraps to 0 after the 9th rising edge and is cleared by START.
- Reset (rst_n=0 at a clk edge), including mid-transaction:
  - State = IDLE; SDA released; filters preset to 1 (bus idle).
  - rx_data = 8'h00; rx_valid, tx_req, start_det, stop_det, addressed, rw = 0.
  - The first START after reset release is recognised normally.

## Timing
- Line-to-filtered latency: 2 + FILTER_LEN clk cycles.
- start_det / stop_det: pulse 1 cycle after the filtered condition edge.
- rx_valid: pulses on the cycle after the filtered 8th rising edge of a write byte. rx_data is valid in the same cycle.
- tx_req: pulses on the cycle after the filtered 9th rising edge (address ACK or master ACK). tx_data must be stable by the next filtered SCL falling edge; it is sampled in that cycle.
- SDA drive update: exactly HOLD_CYCLES clk cycles after the filtered falling edge.
- Minimum clk: 8 × (4 + FILTER_LEN + HOLD_CYCLES) × f_SCL. At the default parameters this gives clk ≥ 88 MHz for 1 MHz SCL, and 50 MHz supports SCL ≤ 500 kHz.
- If START and STOP appear in the same filtered sample (both lines glitching), the first one detected wins. They are mutually exclusive by construction.

## Test plan
- Write: START, 0xA0 (addr 0x50, W), 0xA5, STOP -> ACK on both 9th bits; rx_valid once with rx_data=0xA5; start_det and stop_det each pulse once; addressed drops at STOP.
- Mismatch: START, 0xA2, 0x11, STOP -> SDA never driven low; no rx_valid; addressed stays 0.
- Read: START, 0xA1, tx_data=0x3C then 0xC3, master ACK then NACK, STOP -> bytes 0x3C and 0xC3 on SDA; tx_req pulses exactly twice; SDA released after the NACK.
- Repeated START: write 0xA0, 0x01, then Sr, 0xA1, read one byte with NACK, STOP -> rx_data=0x01; rw goes 0 then 1; start_det pulses twice.
- rx_nack=1 during the second write byte 0x77 -> first byte ACKed, second byte NACKed, rx_valid still pulses with 0x77.
- Robustness: 2-cycle SCL glitch (FILTER_LEN=3) mid-byte -> no extra bit shifted. STOP after 4 bits -> IDLE. rst_n low for 1 cycle during a read byte -> SDA released next cycle and all outputs 0.
